// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI command codes, frame widths and master state encoding
// Used by the SPI master, the SPI slave and the single-port RAM behind it.
package spi_pkg;

  localparam int FRAME_W = 10;  // 2 command bits + 8 payload bits
  localparam int DATA_W  = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_SHIFT  = 3'd2,
    S_TURN   = 3'd3,
    S_RECV   = 3'd4,
    S_END    = 3'd5,
    S_REJECT = 3'd6
  } master_state_e;

endpackage

// File: rtl/spi_master_shifter.sv
// rtl/spi_master_shifter.sv - TX frame and RX byte shift registers for the SPI master
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         parallel-load load_frame into the TX register
//   shift_tx     shift TX register left by one (MSB leaves first)
//   shift_rx     shift rx_bit into the RX register LSB
//   tx_msb       current TX MSB, the next bit to place on MOSI
//   rx_next      RX register contents as they will be after shifting in rx_bit
module spi_master_shifter
  import spi_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [FRAME_W-1:0] load_frame,
  input  logic               shift_tx,
  input  logic               shift_rx,
  input  logic               rx_bit,
  output logic               tx_msb,
  output logic [DATA_W-1:0]  rx_next
);

  logic [FRAME_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0]  rx_q, rx_d;

  // rx_next is exported unconditionally so the controller can register the
  // completed byte on the same edge that captures the last MISO bit.
  assign rx_next = {rx_q[DATA_W-2:0], rx_bit};
  assign tx_msb  = tx_q[FRAME_W-1];

  always_comb begin
    tx_d = tx_q;
    if (load) begin
      tx_d = load_frame;
    end else if (shift_tx) begin
      tx_d = {tx_q[FRAME_W-2:0], 1'b0};
    end
  end

  always_comb begin
    rx_d = rx_q;
    if (shift_rx) begin
      rx_d = rx_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q <= '0;
      rx_q <= '0;
    end else begin
      tx_q <= tx_d;
      rx_q <= rx_d;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - host-side SPI frame generator with read-data turnaround and capture
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   req_valid/req_ready      command handshake (ready only in IDLE)
//   req_cmd, req_data        command code and address/write data
//   rsp_valid/rsp_err        one-cycle response strobe; err marks a rejected read-data command
//   rsp_data                 last read byte, held between responses
//   busy                     high from acceptance until back in IDLE
//   SS_n, MOSI, MISO         serial interface, all synchronous to clk
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int RD_TURNAROUND = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_cmd,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  localparam logic [3:0] SHIFT_LAST = 4'(FRAME_W - 1);
  localparam logic [3:0] TURN_LAST  = 4'(RD_TURNAROUND - 1);
  localparam logic [3:0] RECV_LAST  = 4'(DATA_W - 1);

  master_state_e     state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        cmd_q, cmd_d;
  logic              rd_addr_loaded_q, rd_addr_loaded_d;

  logic              ss_n_q, ss_n_d;
  logic              mosi_q, mosi_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic              load, shift_tx, shift_rx;
  logic              tx_msb;
  logic [DATA_W-1:0] rx_next;
  logic [FRAME_W-1:0] load_frame;

  assign load_frame = {req_cmd, (req_cmd == CMD_RD_DATA) ? {DATA_W{1'b0}} : req_data};

  spi_master_shifter u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_frame (load_frame),
    .shift_tx   (shift_tx),
    .shift_rx   (shift_rx),
    .rx_bit     (MISO),
    .tx_msb     (tx_msb),
    .rx_next    (rx_next)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      cmd_q            <= CMD_WR_ADDR;
      rd_addr_loaded_q <= 1'b0;
      ss_n_q           <= 1'b1;
      mosi_q           <= 1'b0;
      req_ready_q      <= 1'b1;
      busy_q           <= 1'b0;
      rsp_valid_q      <= 1'b0;
      rsp_err_q        <= 1'b0;
      rsp_data_q       <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      cmd_q            <= cmd_d;
      rd_addr_loaded_q <= rd_addr_loaded_d;
      ss_n_q           <= ss_n_d;
      mosi_q           <= mosi_d;
      req_ready_q      <= req_ready_d;
      busy_q           <= busy_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_err_q        <= rsp_err_d;
      rsp_data_q       <= rsp_data_d;
    end
  end

  // Next state, counters and shifter controls.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    cmd_d            = cmd_q;
    rd_addr_loaded_d = rd_addr_loaded_q;
    load             = 1'b0;
    shift_tx         = 1'b0;
    shift_rx         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          cmd_d = req_cmd;
          if (req_cmd == CMD_RD_DATA && !rd_addr_loaded_q) begin
            state_d = S_REJECT;
          end else begin
            state_d = S_CMD;
            load    = 1'b1;
          end
        end
      end
      S_CMD: begin
        // The frame MSB goes out on this edge, so the register advances too.
        state_d  = S_SHIFT;
        cnt_d    = SHIFT_LAST;
        shift_tx = 1'b1;
      end
      S_SHIFT: begin
        if (cnt_q == 4'd0) begin
          if (cmd_q == CMD_RD_DATA) begin
            state_d = S_TURN;
            cnt_d   = TURN_LAST;
          end else begin
            state_d = S_END;
          end
        end else begin
          cnt_d    = cnt_q - 4'd1;
          shift_tx = 1'b1;
        end
      end
      S_TURN: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RECV;
          cnt_d   = RECV_LAST;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RECV: begin
        shift_rx = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = S_END;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_END: begin
        state_d = S_IDLE;
        if (cmd_q == CMD_RD_ADDR) begin
          rd_addr_loaded_d = 1'b1;
        end else if (cmd_q == CMD_RD_DATA) begin
          rd_addr_loaded_d = 1'b0;
        end
      end
      S_REJECT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so that every pin is a flop.
  always_comb begin
    ss_n_d      = 1'b1;
    mosi_d      = 1'b0;
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_d)
      S_CMD: begin
        ss_n_d = 1'b0;
        mosi_d = cmd_d[1];
      end
      S_SHIFT: begin
        ss_n_d = 1'b0;
        mosi_d = tx_msb;
      end
      S_TURN, S_RECV: begin
        ss_n_d = 1'b0;
      end
      S_END: begin
        // Only a read-data frame reaches END straight from RECV.
        if (cmd_d == CMD_RD_DATA) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = rx_next;
        end
      end
      S_REJECT: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;
  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - scoreboard bench for spi_master_ctrl at turnarounds 2, 1 and 15
module tb_spi_master_ctrl;
  import spi_pkg::*;

  localparam int N = 3;

  typedef struct {
    logic [10:0] bits;
    bit          rd;
  } frame_t;

  typedef struct {
    logic       err;
    logic [7:0] data;
  } rsp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req_valid;
  logic [1:0]     req_cmd;
  logic [7:0]     req_data;
  logic [N-1:0]   req_ready, rsp_valid, rsp_err, busy, ss_n, mosi;
  logic [N-1:0]   miso = '1;
  logic [7:0]     rsp_data [N];

  int checks = 0;
  int errors = 0;

  frame_t fexp [$];
  rsp_t   rexp [$];
  int     fidx [N];
  int     ridx [N];

  logic       loaded_m;
  logic [7:0] last_rsp_m;
  bit         b2b_mode;

  int          run [N];
  int          hi [N];
  int          extra [N];
  bit          endf [N];
  logic [10:0] bits [N];
  logic [7:0]  mem [N][256];
  logic [7:0]  waddr [N];
  logic [7:0]  raddr [N];
  logic [7:0]  rbyte [N];

  always #5 clk = ~clk;

  spi_master_ctrl #(.RD_TURNAROUND(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[0]),
    .req_cmd(req_cmd), .req_data(req_data), .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0]), .SS_n(ss_n[0]), .MOSI(mosi[0]), .MISO(miso[0])
  );

  spi_master_ctrl #(.RD_TURNAROUND(1)) u_dut_t1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[1]),
    .req_cmd(req_cmd), .req_data(req_data), .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1]), .SS_n(ss_n[1]), .MOSI(mosi[1]), .MISO(miso[1])
  );

  spi_master_ctrl #(.RD_TURNAROUND(15)) u_dut_t15 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[2]),
    .req_cmd(req_cmd), .req_data(req_data), .rsp_valid(rsp_valid[2]), .rsp_data(rsp_data[2]),
    .rsp_err(rsp_err[2]), .busy(busy[2]), .SS_n(ss_n[2]), .MOSI(mosi[2]), .MISO(miso[2])
  );

  function automatic int ta_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 15;
  endfunction

  task automatic chk(input string name, input int inst, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, inst, act, exp);
    end
  endtask

  task automatic fail(input string name, input int inst);
    checks++;
    errors++;
    $display("FAIL %s[%0d]: event with no expectation", name, inst);
  endtask

  // Waits until every instance is idle (bounded).
  task automatic wait_idle();
    int w = 0;
    while (req_ready != '1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) fail("idle_timeout", 0);
    repeat (2) @(negedge clk);
  endtask

  // Queues the expected frame/response, then hands the command to all instances.
  task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic [7:0] exp_rd,
                       input bit hold, input bit expect_it);
    frame_t f;
    rsp_t   r;
    int     w = 0;
    req_cmd  = c;
    req_data = d;
    if (expect_it) begin
      if (c == CMD_RD_DATA && !loaded_m) begin
        r.err = 1'b1;
        r.data = last_rsp_m;
        rexp.push_back(r);
      end else begin
        f.bits = {c[1], c, (c == CMD_RD_DATA) ? 8'h00 : d};
        f.rd   = (c == CMD_RD_DATA);
        fexp.push_back(f);
        if (c == CMD_RD_ADDR) loaded_m = 1'b1;
        if (c == CMD_RD_DATA) begin
          r.err = 1'b0;
          r.data = exp_rd;
          rexp.push_back(r);
          last_rsp_m = exp_rd;
          loaded_m = 1'b0;
        end
      end
    end
    if (!req_valid) begin
      while (req_ready != '1 && w < 300) begin
        @(negedge clk);
        w++;
      end
    end
    req_valid = 1'b1;
    while (req_ready != '1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) fail("accept_timeout", 0);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  // Monitor, slave/RAM model and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        run[i] = 0;
        hi[i] = 0;
        endf[i] = 0;
        extra[i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        int t;
        int n;
        frame_t e;
        rsp_t r;
        t = ta_of(i);
        chk("busy_vs_ready", i, int'(busy[i]), int'(!req_ready[i]));
        chk("rsp_and_ready", i, int'(rsp_valid[i] & req_ready[i]), 0);
        if (!ss_n[i]) begin
          if (run[i] == 0) begin
            if (b2b_mode) chk("frame_gap", i, hi[i], 2);
            bits[i] = '0;
            extra[i] = 0;
          end
          hi[i] = 0;
          endf[i] = 0;
          run[i]++;
          if (run[i] <= 11) bits[i] = {bits[i][9:0], mosi[i]};
          else if (mosi[i] !== 1'b0) extra[i]++;
          if (run[i] == 11 && bits[i][9:8] == CMD_RD_DATA) rbyte[i] = mem[i][raddr[i]];
          n = run[i];
          // MISO bits are driven during the cycles the master should be sampling;
          // turnaround cycles carry 1s so an early sample corrupts the byte.
          if (n >= 12 + t && n <= 19 + t) miso[i] = rbyte[i][3'(19 + t - n)];
          else miso[i] = 1'b1;
        end else begin
          miso[i] = 1'b1;
          hi[i]++;
          if (endf[i]) begin
            chk("ready_after_end", i, int'(req_ready[i]), 1);
            endf[i] = 0;
          end
          if (run[i] > 0) begin
            chk("ready_in_end", i, int'(req_ready[i]), 0);
            if (fidx[i] >= fexp.size()) begin
              fail("unexpected_frame", i);
            end else begin
              e = fexp[fidx[i]];
              fidx[i]++;
              chk("frame_len", i, run[i], e.rd ? 19 + t : 11);
              chk("frame_bits", i, int'(bits[i]), int'(e.bits));
              chk("mosi_quiet", i, extra[i], 0);
            end
            if (run[i] == 11) begin
              case (bits[i][9:8])
                CMD_WR_ADDR: waddr[i] = bits[i][7:0];
                CMD_WR_DATA: mem[i][waddr[i]] = bits[i][7:0];
                CMD_RD_ADDR: raddr[i] = bits[i][7:0];
                default: ;
              endcase
            end
            run[i] = 0;
            endf[i] = 1;
          end
        end
        if (rsp_valid[i]) begin
          if (ridx[i] >= rexp.size()) begin
            fail("unexpected_rsp", i);
          end else begin
            r = rexp[ridx[i]];
            ridx[i]++;
            chk("rsp_err", i, int'(rsp_err[i]), int'(r.err));
            chk("rsp_data", i, int'(rsp_data[i]), int'(r.data));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog[0]: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    req_valid  = 1'b0;
    req_cmd    = 2'b00;
    req_data   = 8'h00;
    rst_n      = 1'b0;
    b2b_mode   = 1'b0;
    loaded_m   = 1'b0;
    last_rsp_m = 8'h00;
    for (int i = 0; i < N; i++) begin
      fidx[i] = 0;
      ridx[i] = 0;
      waddr[i] = 8'h00;
      raddr[i] = 8'h00;
      rbyte[i] = 8'h00;
      for (int j = 0; j < 256; j++) mem[i][j] = 8'h00;
      mem[i][8'h3C] = 8'h5E;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("ss_n_in_reset", 0, int'(ss_n), 7);
    chk("ready_in_reset", 0, int'(req_ready), 7);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ss_n", 0, int'(ss_n[0]), 1);
    chk("rst_mosi", 0, int'(mosi[0]), 0);
    chk("rst_req_ready", 0, int'(req_ready[0]), 1);
    chk("rst_busy", 0, int'(busy[0]), 0);
    chk("rst_rsp_valid", 0, int'(rsp_valid[0]), 0);
    chk("rst_rsp_err", 0, int'(rsp_err[0]), 0);
    chk("rst_rsp_data", 0, int'(rsp_data[0]), 0);

    // Write address A5, then a read-data with no address loaded.
    issue(CMD_WR_ADDR, 8'hA5, 8'h00, 1'b0, 1'b1);
    wait_idle();
    issue(CMD_RD_DATA, 8'hFF, 8'h00, 1'b0, 1'b1);
    wait_idle();

    // Full read through the RAM model.
    issue(CMD_WR_ADDR, 8'h3C, 8'h00, 1'b0, 1'b1);
    issue(CMD_WR_DATA, 8'h5E, 8'h00, 1'b0, 1'b1);
    issue(CMD_RD_ADDR, 8'h3C, 8'h00, 1'b0, 1'b1);
    issue(CMD_RD_DATA, 8'h00, 8'h5E, 1'b0, 1'b1);
    wait_idle();

    // Byte C3 read back at every turnaround.
    issue(CMD_WR_ADDR, 8'h81, 8'h00, 1'b0, 1'b1);
    issue(CMD_WR_DATA, 8'hC3, 8'h00, 1'b0, 1'b1);
    issue(CMD_RD_ADDR, 8'h81, 8'h00, 1'b0, 1'b1);
    issue(CMD_RD_DATA, 8'h00, 8'hC3, 1'b0, 1'b1);
    wait_idle();

    // Back-to-back with req_valid held high.
    issue(CMD_WR_ADDR, 8'h11, 8'h00, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    b2b_mode = 1'b1;
    issue(CMD_WR_DATA, 8'h22, 8'h00, 1'b1, 1'b1);
    issue(CMD_RD_ADDR, 8'h33, 8'h00, 1'b1, 1'b1);
    issue(CMD_WR_ADDR, 8'h44, 8'h00, 1'b0, 1'b1);
    wait_idle();
    b2b_mode = 1'b0;

    // Reset during SHIFT bit 5 of a frame, then read-data must be rejected.
    issue(CMD_WR_ADDR, 8'h77, 8'h00, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ss_n_async_reset", 0, int'(ss_n), 7);
    chk("rsp_valid_in_reset", 0, int'(rsp_valid), 0);
    loaded_m = 1'b0;
    last_rsp_m = 8'h00;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    issue(CMD_RD_DATA, 8'h00, 8'h00, 1'b0, 1'b1);
    wait_idle();
    repeat (5) @(negedge clk);

    for (int i = 0; i < N; i++) begin
      chk("frames_seen", i, fidx[i], fexp.size());
      chk("rsps_seen", i, ridx[i], rexp.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
